// File: rtl/subtrator_serial_param_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and the
// elaboration-time legality check for the WIDTH / DIGIT_W pair.
package subtrator_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    // WIDTH must be positive and an exact multiple of a non-zero DIGIT_W
    function automatic bit params_ok(input int width, input int digit_w);
        return (width >= 1) && (digit_w >= 1) && (digit_w <= width) &&
               ((width % digit_w) == 0);
    endfunction

endpackage

// File: rtl/subtrator_serial_param_if.sv
// Request/result bundle of the serial subtractor.
// The ovf signal exists only when SUBTRATOR_OVF_EN is defined.
interface subtrator_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             borrow_out;
`ifdef SUBTRATOR_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, d, borrow_out
`ifdef SUBTRATOR_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, d, borrow_out
`ifdef SUBTRATOR_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/subtrator_serial_param_fatia.sv
// Combinational DIGIT_W-bit ripple-borrow subtractor slice: d = a - b - borrow_in.
module subtrator_fatia #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] d,
    output logic               borrow_out
);
    logic [DIGIT_W:0] chain_s;

    // ripple the borrow from the LSB upward, one full subtractor per bit
    always_comb begin
        chain_s    = '0;
        d          = '0;
        chain_s[0] = borrow_in;
        for (int i = 0; i < DIGIT_W; i++) begin
            d[i]         = a[i] ^ b[i] ^ chain_s[i];
            chain_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain_s[i]);
        end
        borrow_out = chain_s[DIGIT_W];
    end
endmodule

// File: rtl/subtrator_serial_param.sv
// Multi-cycle subtractor: a - b - borrow_in over WIDTH bits, DIGIT_W bits per
// clock, LSB first. Optional signed overflow flag under SUBTRATOR_OVF_EN.
module subtrator_serial_param
    import subtrator_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    subtrator_serial_param_if.slave bus
);
    localparam int NSTEPS = WIDTH / DIGIT_W;
    localparam int CNT_W  = $clog2(NSTEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

    generate
        if (!params_ok(WIDTH, DIGIT_W)) begin : g_param_check
            $error("subtrator_serial_param: WIDTH must be a multiple of DIGIT_W, 1 <= DIGIT_W <= WIDTH");
        end
    endgenerate

    state_t             state_r;
    state_t             state_next_s;
    logic               accept_s;
    logic               step_s;
    logic               finish_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               borrow_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   acc_next_s;
    logic [DIGIT_W-1:0] diff_s;
    logic               borrow_next_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   d_r;
    logic               borrow_out_r;
`ifdef SUBTRATOR_OVF_EN
    logic               a_msb_r;
    logic               b_msb_r;
    logic               ovf_r;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: start only matters in IDLE, CALC leaves after the last step
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_next_s = ST_CALC;
                else           state_next_s = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == LAST_STEP) state_next_s = ST_IDLE;
                else                    state_next_s = ST_CALC;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath load / step / completion strobes
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) accept_s = 1'b1;
                else           accept_s = 1'b0;
            end
            ST_CALC: begin
                step_s = 1'b1;
                if (cnt_r == LAST_STEP) finish_s = 1'b1;
                else                    finish_s = 1'b0;
            end
            default: begin
                accept_s = 1'b0;
                step_s   = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    subtrator_fatia #(
        .DIGIT_W (DIGIT_W)
    ) u_fatia (
        .a          (a_sh_r[DIGIT_W-1:0]),
        .b          (b_sh_r[DIGIT_W-1:0]),
        .borrow_in  (borrow_r),
        .d          (diff_s),
        .borrow_out (borrow_next_s)
    );

    // result accumulator fills from the MSB side so the last step leaves it aligned
    always_comb begin
        acc_next_s                        = acc_r >> DIGIT_W;
        acc_next_s[WIDTH-1 -: DIGIT_W]    = diff_s;
    end

    // operand shifters, borrow chain register, step counter and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
`ifdef SUBTRATOR_OVF_EN
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r   <= bus.a;
            b_sh_r   <= bus.b;
            borrow_r <= bus.borrow_in;
            cnt_r    <= '0;
            acc_r    <= '0;
`ifdef SUBTRATOR_OVF_EN
            a_msb_r  <= bus.a[WIDTH-1];
            b_msb_r  <= bus.b[WIDTH-1];
`endif
        end else if (step_s) begin
            a_sh_r   <= a_sh_r >> DIGIT_W;
            b_sh_r   <= b_sh_r >> DIGIT_W;
            borrow_r <= borrow_next_s;
            cnt_r    <= cnt_r + CNT_W'(1);
            acc_r    <= acc_next_s;
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            borrow_r <= borrow_r;
            cnt_r    <= cnt_r;
            acc_r    <= acc_r;
        end
    end

    // visible outputs: status every cycle, results only on the completion edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            d_r          <= '0;
            borrow_out_r <= 1'b0;
`ifdef SUBTRATOR_OVF_EN
            ovf_r        <= 1'b0;
`endif
        end else begin
            busy_r <= (state_next_s == ST_CALC);
            done_r <= finish_s;
            if (finish_s) begin
                d_r          <= acc_next_s;
                borrow_out_r <= borrow_next_s;
`ifdef SUBTRATOR_OVF_EN
                ovf_r        <= (a_msb_r != b_msb_r) && (acc_next_s[WIDTH-1] != a_msb_r);
`endif
            end else begin
                d_r          <= d_r;
                borrow_out_r <= borrow_out_r;
`ifdef SUBTRATOR_OVF_EN
                ovf_r        <= ovf_r;
`endif
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.d          = d_r;
    assign bus.borrow_out = borrow_out_r;
`ifdef SUBTRATOR_OVF_EN
    assign bus.ovf        = ovf_r;
`endif

endmodule

// File: tb/tb_subtrator_serial_param.sv
// Scoreboard bench for subtrator_serial_param: three instances
// (8/1, 1/1, 8/4). ovf is checked only when SUBTRATOR_OVF_EN is defined.
module tb_subtrator_serial_param;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    subtrator_serial_param_if #(.WIDTH(8)) ia ();
    subtrator_serial_param_if #(.WIDTH(1)) ib ();
    subtrator_serial_param_if #(.WIDTH(8)) ic ();

    subtrator_serial_param #(.WIDTH(8), .DIGIT_W(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    subtrator_serial_param #(.WIDTH(1), .DIGIT_W(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    subtrator_serial_param #(.WIDTH(8), .DIGIT_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input logic s, input logic [7:0] av, input logic [7:0] bv, input logic bi);
        case (sel)
            0: begin ia.start = s; ia.a = av; ia.b = bv; ia.borrow_in = bi; end
            1: begin ib.start = s; ib.a = av[0]; ib.b = bv[0]; ib.borrow_in = bi; end
            default: begin ic.start = s; ic.a = av; ic.b = bv; ic.borrow_in = bi; end
        endcase
    endtask

    function automatic logic rd_busy(input int sel);
        case (sel)
            0: return ia.busy;
            1: return ib.busy;
            default: return ic.busy;
        endcase
    endfunction

    function automatic logic rd_done(input int sel);
        case (sel)
            0: return ia.done;
            1: return ib.done;
            default: return ic.done;
        endcase
    endfunction

    function automatic logic [7:0] rd_d(input int sel);
        case (sel)
            0: return ia.d;
            1: return {7'd0, ib.d};
            default: return ic.d;
        endcase
    endfunction

    function automatic logic rd_bo(input int sel);
        case (sel)
            0: return ia.borrow_out;
            1: return ib.borrow_out;
            default: return ic.borrow_out;
        endcase
    endfunction

`ifdef SUBTRATOR_OVF_EN
    function automatic logic rd_ov(input int sel);
        case (sel)
            0: return ia.ovf;
            1: return ib.ovf;
            default: return ic.ovf;
        endcase
    endfunction
`endif

    // reference arithmetic in plain integers, width 1 or 8
    function automatic exp_t model(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic bi);
        exp_t e;
        int w, mask, ai, bb, diff, dm;
        w    = (sel == 1) ? 1 : 8;
        mask = (1 << w) - 1;
        ai   = int'(av) & mask;
        bb   = int'(bv) & mask;
        diff = ai - bb - int'(bi);
        dm   = diff & mask;
        e.d  = 8'(dm);
        e.bo = (diff < 0);
        e.ov = (((ai >> (w-1)) & 1) != ((bb >> (w-1)) & 1)) &&
               (((dm >> (w-1)) & 1) != ((ai >> (w-1)) & 1));
        return e;
    endfunction

    // wait up to 40 edges for done; returns edges waited (0 = timeout) and busy-high samples
    task automatic wait_done(input int sel, output int lat, inout int bcnt);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (rd_done(sel)) begin
                lat = n;
                break;
            end
            if (rd_busy(sel)) bcnt++;
        end
    endtask

    task automatic compare_result(input int sel, input string name);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (rd_d(sel) !== e.d) begin
            errors++;
            $display("FAIL %s d: got %02h expected %02h", name, rd_d(sel), e.d);
        end
        checks++;
        if (rd_bo(sel) !== e.bo) begin
            errors++;
            $display("FAIL %s borrow_out: got %0b expected %0b", name, rd_bo(sel), e.bo);
        end
`ifdef SUBTRATOR_OVF_EN
        checks++;
        if (rd_ov(sel) !== e.ov) begin
            errors++;
            $display("FAIL %s ovf: got %0b expected %0b", name, rd_ov(sel), e.ov);
        end
`endif
    endtask

    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          input int exp_lat, input string name);
        int lat, bcnt;
        sb.push_back(model(sel, av, bv, bi));
        @(negedge clk);
        drive(sel, 1'b1, av, bv, bi);
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'd0, 8'd0, 1'b0);
        bcnt = rd_busy(sel) ? 1 : 0;
        wait_done(sel, lat, bcnt);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (bcnt != exp_lat) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, exp_lat);
        end
        if (lat != 0) compare_result(sel, name);
        else void'(sb.pop_front());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({rd_busy(s), rd_done(s), rd_bo(s), rd_d(s)} !== 11'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got busy=%0b done=%0b bo=%0b d=%02h expected all 0",
                         s, rd_busy(s), rd_done(s), rd_bo(s), rd_d(s));
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_op(0, 8'h05, 8'h03, 1'b0, 8, "basic_05_03");
    endtask

    task automatic test_borrow();
        run_op(0, 8'h00, 8'h01, 1'b0, 8, "wrap_00_01");
        run_op(0, 8'h03, 8'h03, 1'b1, 8, "wrap_03_03_b1");
        run_op(0, 8'hA5, 8'h5A, 1'b1, 8, "mix_a5_5a_b1");
        run_op(0, 8'hFF, 8'hFF, 1'b1, 8, "ff_ff_b1");
    endtask

    task automatic test_ovf();
        run_op(0, 8'h80, 8'h01, 1'b0, 8, "ovf_80_01");
        run_op(0, 8'h7F, 8'hFF, 1'b0, 8, "ovf_7f_ff");
    endtask

    task automatic test_width1();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            run_op(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1, $sformatf("fs_%0d%0d%0d", v[2], v[1], v[0]));
        end
    endtask

    task automatic test_digit4();
        run_op(2, 8'h10, 8'h01, 1'b0, 2, "d4_10_01");
        run_op(2, 8'h00, 8'hFF, 1'b1, 2, "d4_00_ff_b1");
    endtask

    task automatic test_ignore_start();
        int lat, bcnt, extra;
        sb.push_back(model(2, 8'h33, 8'h11, 1'b0));
        @(negedge clk);
        drive(2, 1'b1, 8'h33, 8'h11, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b1, 8'hF0, 8'h0F, 1'b1);
        @(posedge clk); #1;
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
        bcnt = 0;
        wait_done(2, lat, bcnt);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL ignore_start latency: got %0d expected 1", lat);
        end
        if (lat != 0) compare_result(2, "ignore_start");
        else void'(sb.pop_front());
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rd_done(2) || rd_busy(2)) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_start queued: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        sb.push_back(model(2, 8'h44, 8'h45, 1'b0));
        @(negedge clk);
        drive(2, 1'b1, 8'h44, 8'h45, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
        bcnt = 0;
        wait_done(2, lat, bcnt);
        if (lat != 0) compare_result(2, "b2b_first");
        else void'(sb.pop_front());
        // still inside the done cycle: issue the next request
        sb.push_back(model(2, 8'hC8, 8'h37, 1'b1));
        drive(2, 1'b1, 8'hC8, 8'h37, 1'b1);
        @(posedge clk); #1;
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
        checks++;
        if (rd_busy(2) !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy: got %0b expected 1", rd_busy(2));
        end
        bcnt = 0;
        wait_done(2, lat, bcnt);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL b2b_second latency: got %0d expected 2", lat);
        end
        if (lat != 0) compare_result(2, "b2b_second");
        else void'(sb.pop_front());
    endtask

    task automatic test_mid_reset();
        int late;
        @(negedge clk);
        drive(0, 1'b1, 8'h05, 8'h03, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rd_busy(0), rd_done(0), rd_bo(0), rd_d(0)} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%0b done=%0b bo=%0b d=%02h expected all 0",
                     rd_busy(0), rd_done(0), rd_bo(0), rd_d(0));
        end
        rst_n = 1'b1;
        late = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rd_done(0)) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL mid_reset late_done: got %0d expected 0", late);
        end
        run_op(0, 8'h05, 8'h03, 1'b0, 8, "after_reset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_ovf();
        test_width1();
        test_digit4();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
